// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Write-back source indices, load-size codes and skid states.
// Revision    : 1.0
// ============================================================================
package wb_pkg;

    localparam int SRC_ALU      = 0;
    localparam int SRC_MEM      = 1;
    localparam int SRC_PC4      = 2;
    localparam int SRC_IMM      = 3;
    localparam int SRC_EXT_BASE = 4;

    localparam logic [1:0] LD_BYTE  = 2'b00;
    localparam logic [1:0] LD_HALF  = 2'b01;
    localparam logic [1:0] LD_WORD  = 2'b10;
    localparam logic [1:0] LD_DWORD = 2'b11;

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    function automatic int ext_width(input int data_w, input int nsrc);
        return (nsrc > 4) ? (nsrc - 4) * data_w : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_select_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_select_stage_if
// Description : Upstream result bus and register-file/forwarding bus.
// Revision    : 1.0
// ============================================================================
interface wb_select_stage_if
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NSRC    = 4,
    parameter int RADDR_W = 5
);
    localparam int SEL_W = $clog2(NSRC);
    localparam int EXT_W = ext_width(DATA_W, NSRC);

    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   in_sel;
    logic [DATA_W-1:0]  src_alu;
    logic [DATA_W-1:0]  src_mem;
    logic [DATA_W-1:0]  src_pc4;
    logic [DATA_W-1:0]  src_imm;
    logic [EXT_W-1:0]   src_ext;
    logic [1:0]         ld_size;
    logic               ld_unsigned;
    logic [2:0]         byte_off;
    logic [RADDR_W-1:0] in_rd;
    logic               in_we;
    logic               out_valid;
    logic               out_ready;
    logic               wr_en;
    logic [RADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               fwd_hit_valid;
    logic [RADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0]  fwd_data;

    modport master (
        output in_valid, in_sel, src_alu, src_mem, src_pc4, src_imm, src_ext,
               ld_size, ld_unsigned, byte_off, in_rd, in_we, out_ready,
        input  in_ready, out_valid, wr_en, wr_addr, wr_data,
               fwd_hit_valid, fwd_addr, fwd_data
    );

    modport slave (
        input  in_valid, in_sel, src_alu, src_mem, src_pc4, src_imm, src_ext,
               ld_size, ld_unsigned, byte_off, in_rd, in_we, out_ready,
        output in_ready, out_valid, wr_en, wr_addr, wr_data,
               fwd_hit_valid, fwd_addr, fwd_data
    );

endinterface
`default_nettype wire

// File: rtl/wb_load_align.sv
`default_nettype none
// ============================================================================
// Module      : wb_load_align
// Description : Extracts and sign/zero-extends the loaded lane of src_mem.
// Revision    : 1.0
// ============================================================================
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic [DATA_W-1:0] src_mem,
    input  wire logic [1:0]        ld_size,
    input  wire logic              ld_unsigned,
    input  wire logic [2:0]        byte_off,
    output logic      [DATA_W-1:0] load_data
);

    // A 32-bit datapath has only four byte lanes, so the top offset bit drops out.
    localparam logic [2:0] c_off_mask = (DATA_W == 64) ? 3'd7 : 3'd3;

    logic [2:0]        w_off;
    logic [31:0]       w_low;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_dword;
    logic              w_sign_b;
    logic              w_sign_h;

    always_comb begin
        w_off = 3'd0;
        case (ld_size)
            LD_BYTE: w_off = byte_off & c_off_mask;
            LD_HALF: w_off = {byte_off[2:1], 1'b0} & c_off_mask;
            LD_WORD: w_off = {byte_off[2], 2'b00} & c_off_mask;
            default: w_off = 3'd0;
        endcase
    end

    assign w_low    = 32'(src_mem >> {w_off, 3'b000});
    assign w_sign_b = ~ld_unsigned & w_low[7];
    assign w_sign_h = ~ld_unsigned & w_low[15];

    generate
        if (DATA_W == 64) begin : g_w64
            assign w_word  = {{32{~ld_unsigned & w_low[31]}}, w_low};
            assign w_dword = src_mem;
        end else begin : g_w32
            assign w_word  = w_low;
            assign w_dword = w_low;
        end
    endgenerate

    always_comb begin
        load_data = w_word;
        case (ld_size)
            LD_BYTE:  load_data = {{(DATA_W-8){w_sign_b}}, w_low[7:0]};
            LD_HALF:  load_data = {{(DATA_W-16){w_sign_h}}, w_low[15:0]};
            LD_WORD:  load_data = w_word;
            default:  load_data = w_dword;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_select_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_select_stage
// Description : Write-back source select with a 2-entry skid output buffer.
// Revision    : 1.0
// ============================================================================
module wb_select_stage
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NSRC    = 4,
    parameter int RADDR_W = 5
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    wb_select_stage_if.slave bus
);

    logic [DATA_W-1:0]  w_load_data;
    logic [DATA_W-1:0]  w_ext_data;
    logic               w_ext_hit;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_accept;
    logic               w_drain;
    logic               w_out_valid;
    logic               w_main_live;

    logic [1:0]         r_state;
    logic               r_in_ready;
    logic [DATA_W-1:0]  r_main_data;
    logic [RADDR_W-1:0] r_main_rd;
    logic               r_main_we;
    logic [DATA_W-1:0]  r_skid_data;
    logic [RADDR_W-1:0] r_skid_rd;
    logic               r_skid_we;

    wb_load_align #(.DATA_W(DATA_W)) u_load_align (
        .src_mem     (bus.src_mem),
        .ld_size     (bus.ld_size),
        .ld_unsigned (bus.ld_unsigned),
        .byte_off    (bus.byte_off),
        .load_data   (w_load_data)
    );

    generate
        if (NSRC > 4) begin : g_ext
            always_comb begin
                w_ext_data = bus.src_alu;
                w_ext_hit  = 1'b0;
                for (int k = 0; k < NSRC - 4; k++) begin
                    if (int'(bus.in_sel) == SRC_EXT_BASE + k) begin
                        w_ext_data = bus.src_ext[k*DATA_W +: DATA_W];
                        w_ext_hit  = 1'b1;
                    end
                end
            end
        end else begin : g_no_ext
            logic w_unused_ext;
            assign w_unused_ext = ^bus.src_ext;
            assign w_ext_data   = bus.src_alu;
            assign w_ext_hit    = 1'b0;
        end
    endgenerate

    // Indices at or above NSRC fall back to the ALU result.
    always_comb begin
        w_sel_data = bus.src_alu;
        if (int'(bus.in_sel) == SRC_MEM && NSRC > SRC_MEM)
            w_sel_data = w_load_data;
        else if (int'(bus.in_sel) == SRC_PC4 && NSRC > SRC_PC4)
            w_sel_data = bus.src_pc4;
        else if (int'(bus.in_sel) == SRC_IMM && NSRC > SRC_IMM)
            w_sel_data = bus.src_imm;
        else if (w_ext_hit)
            w_sel_data = w_ext_data;
    end

    assign w_out_valid = (r_state != c_st_empty);
    assign w_accept    = bus.in_valid & r_in_ready;
    assign w_drain     = w_out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_empty;
            r_in_ready  <= 1'b0;
            r_main_data <= '0;
            r_main_rd   <= '0;
            r_main_we   <= 1'b0;
            r_skid_data <= '0;
            r_skid_rd   <= '0;
            r_skid_we   <= 1'b0;
        end else begin
            case (r_state)
                c_st_empty: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_main_data <= w_sel_data;
                        r_main_rd   <= bus.in_rd;
                        r_main_we   <= bus.in_we;
                        r_state     <= c_st_one;
                    end
                end
                c_st_one: begin
                    r_in_ready <= 1'b1;
                    if (w_accept && w_drain) begin
                        r_main_data <= w_sel_data;
                        r_main_rd   <= bus.in_rd;
                        r_main_we   <= bus.in_we;
                    end else if (w_accept) begin
                        r_skid_data <= w_sel_data;
                        r_skid_rd   <= bus.in_rd;
                        r_skid_we   <= bus.in_we;
                        r_state     <= c_st_full;
                        r_in_ready  <= 1'b0;
                    end else if (w_drain) begin
                        r_state     <= c_st_empty;
                    end
                end
                c_st_full: begin
                    // The older entry leaves first; the skid entry moves up.
                    if (w_drain) begin
                        r_main_data <= r_skid_data;
                        r_main_rd   <= r_skid_rd;
                        r_main_we   <= r_skid_we;
                        r_state     <= c_st_one;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_in_ready  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= c_st_empty;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign w_main_live       = w_out_valid & r_main_we & (r_main_rd != '0);
    assign bus.in_ready      = r_in_ready;
    assign bus.out_valid     = w_out_valid;
    assign bus.wr_en         = w_main_live & bus.out_ready;
    assign bus.wr_addr       = r_main_rd;
    assign bus.wr_data       = r_main_data;
    assign bus.fwd_hit_valid = w_main_live;
    assign bus.fwd_addr      = r_main_rd;
    assign bus.fwd_data      = r_main_data;

endmodule
`default_nettype wire

// File: doc/wb_select_stage.md
WB_SELECT_STAGE -- requirements
Module: wb_select_stage

Interface
REQ-001 Parameter DATA_W, default 32: datapath width in bits; legal values are 32 and 64.
REQ-002 Parameter NSRC, default 4: number of write-back sources; legal range is 2..8.
REQ-003 Parameter RADDR_W, default 5: width of the register-file address.
REQ-004 Port clk  input  1: single clock; all state changes on the rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 Port in_valid  input  1: the upstream presents an instruction result.
REQ-007 Port in_ready  output  1: the stage can accept a result.
REQ-008 Port in_sel  input  clog2(NSRC): source select; 0=ALU, 1=MEM, 2=PC+4, 3=IMM, indices 4 and up map to src_ext.
REQ-009 Port src_alu, src_mem, src_pc4, src_imm  input  DATA_W each: candidate write-back data.
REQ-010 Port src_ext  input  (NSRC-4)*DATA_W, minimum width 1: extra sources; a dummy when NSRC<=4.
REQ-011 Port ld_size  input  2: load size for the MEM source; 00=byte, 01=half, 10=word, 11=dword.
REQ-012 Port ld_unsigned  input  1: zero-extend the loaded value instead of sign-extending it.
REQ-013 Port byte_off  input  3: byte offset of the load within src_mem.
REQ-014 Port in_rd  input  RADDR_W: destination register address.
REQ-015 Port in_we  input  1: the instruction writes a register.
REQ-016 Port out_valid  output  1: a registered result is present at the output.
REQ-017 Port out_ready  input  1: the register file or downstream consumes the result.
REQ-018 Port wr_en, wr_addr, wr_data  output  1/RADDR_W/DATA_W: register-file write port.
REQ-019 Port fwd_hit_valid, fwd_addr, fwd_data  output  1/RADDR_W/DATA_W: forwarding view of the output entry.

Function
REQ-020 The selected data is formed combinationally from in_sel; an out-of-range in_sel selects src_alu.
REQ-021 MEM source, byte load: byte lane byte_off is taken from src_mem; at DATA_W=32 only byte_off[1:0] is used.
REQ-022 MEM source, half load: half-word lane byte_off[2:1] is taken from src_mem; byte_off[0] is ignored.
REQ-023 MEM source, word load: word lane byte_off[2] is taken from src_mem; at DATA_W=32 the full word is used.
REQ-024 MEM source, dword load: the full src_mem is used; at DATA_W=32, ld_size 11 is treated as word.
REQ-025 Loaded values are sign-extended to DATA_W unless ld_unsigned is 1, in which case they are zero-extended.
REQ-026 A transfer occurs on a clock edge where in_valid and in_ready are both 1; the formed data, rd, and we are captured.
REQ-027 Buffering is a 2-entry skid: a main output register plus one skid register; states are EMPTY, ONE and FULL.
REQ-028 State transitions:
  - EMPTY goes to ONE on an accept.
  - ONE goes to FULL on an accept without a drain.
  - ONE goes to EMPTY on a drain without an accept.
  - ONE stays in ONE on an accept and a drain in the same cycle.
  - FULL goes to ONE on a drain.
REQ-029 A drain occurs when out_valid and out_ready are both 1.
REQ-030 in_ready is registered and equals (state != FULL); in_ready is never combinationally dependent on out_ready.
REQ-031 In FULL, a drain moves the skid entry into the main register on the same edge; result order is preserved.
REQ-032 out_valid = (state != EMPTY); wr_addr and wr_data are driven from the main register.
REQ-033 wr_en = out_valid & out_ready & we & (rd != 0); a write to x0 never asserts wr_en, but it still drains.
REQ-034 fwd_hit_valid = out_valid & we & (rd != 0), independent of out_ready; fwd_addr and fwd_data mirror the main register.
REQ-035 Latency is exactly 1 cycle from accept to out_valid when the stage is empty.
REQ-036 Sustained throughput is 1 result per cycle while out_ready stays 1.

Reset
REQ-037 When rst_n is 0: state=EMPTY, in_ready=0, out_valid=0, wr_en=0, fwd_hit_valid=0, and all data/address registers are 0.
REQ-038 in_ready rises on the first clock edge after rst_n deasserts.
REQ-039 A reset asserted mid-operation discards both buffered entries with no write.

Structure
REQ-040 Package wb_pkg holds the source-index constants (SRC_ALU, SRC_MEM, SRC_PC4, SRC_IMM) and the ld_size encodings.
REQ-041 One sub-module, wb_load_align, implements REQ-021..REQ-025 combinationally; the skid FSM lives in the top module.

Verification
REQ-042 in_sel=1, ld_size=00, byte_off=3, src_mem=0x80FF_0000, ld_unsigned=0 -> wr_data=0xFFFF_FF80 one cycle later.
REQ-043 in_sel=1, ld_size=01, byte_off=2, src_mem=0x8001_1234, ld_unsigned=1 -> wr_data=0x0000_8001.
REQ-044 Two results accepted while out_ready=0 -> in_ready=0 after the second accept; releasing out_ready drains A then B in order; in_ready returns to 1 on the first drain.
REQ-045 in_rd=0, in_we=1, out_ready=1 -> wr_en stays 0 and fwd_hit_valid stays 0; the stage returns to EMPTY.
REQ-046 Back-to-back valid results with out_ready=1 for 8 cycles -> 8 writes on consecutive cycles with no bubbles.
REQ-047 State FULL with rst_n pulsed low -> outputs go to 0 immediately; no wr_en after release; in_ready=1 one edge later.
